l1_mmu_arbiter: RTL and testbench

//  Shares the single MMU line port between the L1 I-cache (read-only refills) and the L1 D-cache
//  (line writebacks, refills, MMIO accesses). Latches the winner's request at grant and presents it
//  to the MMU. Routes mmu done/data back to the owner only. Flags a stuck MMU with a watchdog.

---
 rtl/l1_mmu_arbiter_if.sv | 55 +++++
 rtl/l1_mmu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_l1_mmu_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/l1_mmu_arbiter_if.sv
// l1_mmu_arbiter_if
//   Bundles the I-cache, D-cache and MMU line-port signals that meet at the
//   L1 MMU arbiter.
//   modport slave  : the arbiter side (takes cache requests, drives the MMU)
//   modport master : the environment side (caches + MMU), the mirror image
//   Signals:
//     ic_req_read/ic_req_addr           I-cache refill request
//     ic_done/ic_read_data              completion back to the I-cache
//     dc_req_read/dc_req_write          D-cache request type (level)
//     dc_req_addr/dc_write_data         D-cache request address / write line
//     dc_done/dc_read_data              completion back to the D-cache
//     mmu_req_read/mmu_req_write        forwarded request type
//     mmu_req_addr/mmu_write_data       forwarded (latched) address / data
//     mmu_done/mmu_read_data            MMU completion
//     arb_timeout                       sticky watchdog error
interface l1_mmu_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              ic_req_read;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_done;
    logic [LINE_W-1:0] ic_read_data;
    logic              dc_req_read;
    logic              dc_req_write;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_done;
    logic [LINE_W-1:0] dc_read_data;
    logic              mmu_req_read;
    logic              mmu_req_write;
    logic [ADDR_W-1:0] mmu_req_addr;
    logic [LINE_W-1:0] mmu_write_data;
    logic              mmu_done;
    logic [LINE_W-1:0] mmu_read_data;
    logic              arb_timeout;

    modport slave (
        input  ic_req_read, ic_req_addr,
        input  dc_req_read, dc_req_write, dc_req_addr, dc_write_data,
        input  mmu_done, mmu_read_data,
        output ic_done, ic_read_data, dc_done, dc_read_data,
        output mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data,
        output arb_timeout
    );

    modport master (
        output ic_req_read, ic_req_addr,
        output dc_req_read, dc_req_write, dc_req_addr, dc_write_data,
        output mmu_done, mmu_read_data,
        input  ic_done, ic_read_data, dc_done, dc_read_data,
        input  mmu_req_read, mmu_req_write, mmu_req_addr, mmu_write_data,
        input  arb_timeout
    );
endinterface

// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter
//   Shares the single MMU line port between the L1 I-cache (refill reads) and
//   the L1 D-cache (writebacks, refills, MMIO). The winner's request is
//   latched at grant and presented to the MMU from the latch; mmu_done and
//   mmu_read_data are routed combinationally to the current owner only.
//   A watchdog raises a sticky arb_timeout if a grant runs too long.
//   Ports:
//     sys_clk  single clock, all state on posedge
//     rst_n    asynchronous active-low reset
//     bus      l1_mmu_arbiter_if.slave (cache requests, MMU port, timeout)
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   : conflicts go to the requester that did not own the last
//                 completed transaction (writeback chaining still overrides)
//     undefined : fixed D-cache-over-I-cache priority
module l1_mmu_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               sys_clk,
    input logic               rst_n,
    l1_mmu_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic              ic_req, dc_req, pick_d;
    logic              in_gnt, grant_entry;
    logic              timeout_hit, timeout_q;

    assign ic_req = bus.ic_req_read;
    assign dc_req = bus.dc_req_read | bus.dc_req_write;

`ifdef ARB_ROUND_ROBIN_EN
    // last_owner: 1 = D-cache owned the last completed transaction.
    // chain: set when a D write completes so the D refill that follows the
    // writeback beats a pending I-cache request in the next IDLE.
    logic last_owner_q, last_owner_d;
    logic chain_q, chain_d;

    assign pick_d = dc_req &&
                    (!ic_req || (chain_q && bus.dc_req_read) || !last_owner_q);

    always_comb begin
        last_owner_d = last_owner_q;
        chain_d      = chain_q;
        if (state_q == GNT_I && bus.mmu_done) begin
            last_owner_d = 1'b0;
        end
        if (state_q == GNT_D && bus.mmu_done) begin
            last_owner_d = 1'b1;
            chain_d      = is_write_q;
        end
        if (grant_entry) begin
            chain_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= 1'b0;
            chain_q      <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            chain_q      <= chain_d;
        end
    end
`else
    // Fixed priority: D always wins, which also satisfies writeback chaining.
    assign pick_d = dc_req;
`endif

    // Next state and request latch
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d    = GNT_D;
                    addr_d     = bus.dc_req_addr;
                    wdata_d    = bus.dc_write_data;
                    is_write_d = bus.dc_req_write;   // write wins if both set
                end else if (ic_req) begin
                    state_d    = GNT_I;
                    addr_d     = bus.ic_req_addr;
                    wdata_d    = '0;
                    is_write_d = 1'b0;
                end
            end
            GNT_I, GNT_D: begin
                // Requests are not re-examined: a dropped request still completes.
                if (bus.mmu_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
        end
    end

    assign in_gnt      = (state_q != IDLE);
    assign grant_entry = (state_q == IDLE) && (state_d != IDLE);

    // Watchdog
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             to_d;

        // Combinational hit so the flag shows on the TIMEOUT_CYCLES-th grant cycle.
        assign timeout_hit = in_gnt && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        always_comb begin
            cnt_d = cnt_q;
            to_d  = timeout_q | timeout_hit;
            if (grant_entry) begin
                cnt_d = '0;
            end else if (in_gnt && !bus.mmu_done && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= '0;
                timeout_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                timeout_q <= to_d;
            end
        end
    end else begin : g_no_wdog
        assign timeout_hit = 1'b0;
        assign timeout_q   = 1'b0;
    end

    // Outputs: MMU side from the latch, done/data only to the owner
    assign bus.mmu_req_read   = in_gnt && !is_write_q;
    assign bus.mmu_req_write  = in_gnt &&  is_write_q;
    assign bus.mmu_req_addr   = addr_q;
    assign bus.mmu_write_data = wdata_q;
    assign bus.ic_done        = (state_q == GNT_I) && bus.mmu_done;
    assign bus.dc_done        = (state_q == GNT_D) && bus.mmu_done;
    assign bus.ic_read_data   = bus.ic_done ? bus.mmu_read_data : '0;
    assign bus.dc_read_data   = bus.dc_done ? bus.mmu_read_data : '0;
    assign bus.arb_timeout    = timeout_q | timeout_hit;
endmodule

// File: tb/tb_l1_mmu_arbiter.sv
module tb_l1_mmu_arbiter;
    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    l1_mmu_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

    l1_mmu_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT_CYCLES(8)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vector %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge sys_clk);
    endtask

    // Raise mmu_done for the current cycle; caller checks, then cyc() and mmu_idle().
    task automatic mmu_ack(input logic [255:0] data);
        bus.mmu_done      = 1'b1;
        bus.mmu_read_data = data;
        #1;
    endtask

    task automatic mmu_idle();
        bus.mmu_done      = 1'b0;
        bus.mmu_read_data = '0;
        #1;
    endtask

    logic [255:0] a5_line;
    logic [31:0]  rr_exp [3];

    initial begin
        a5_line = {8{32'hA5A5_A5A5}};
        bus.ic_req_read   = 1'b0;
        bus.ic_req_addr   = '0;
        bus.dc_req_read   = 1'b0;
        bus.dc_req_write  = 1'b0;
        bus.dc_req_addr   = '0;
        bus.dc_write_data = '0;
        bus.mmu_done      = 1'b0;
        bus.mmu_read_data = '0;

        // Reset values
        cyc(); cyc();
        chk("rst_req_read",  256'(bus.mmu_req_read),  256'd0);
        chk("rst_req_write", 256'(bus.mmu_req_write), 256'd0);
        chk("rst_addr",      256'(bus.mmu_req_addr),  256'd0);
        chk("rst_timeout",   256'(bus.arb_timeout),   256'd0);
        rst_n = 1'b1;

        // Reset asserted in the middle of a D write grant
        bus.dc_req_write  = 1'b1;
        bus.dc_req_addr   = 32'h3000;
        bus.dc_write_data = 256'h55;
        cyc();
        chk("gntd_write", 256'(bus.mmu_req_write), 256'd1);
        chk("gntd_addr",  256'(bus.mmu_req_addr),  256'h3000);
        rst_n = 1'b0;
        #1;
        chk("midrst_write", 256'(bus.mmu_req_write), 256'd0);
        chk("midrst_addr",  256'(bus.mmu_req_addr),  256'd0);
        chk("midrst_wdata", bus.mmu_write_data,      256'd0);
        bus.dc_req_write  = 1'b0;
        bus.dc_write_data = '0;
        cyc();
        rst_n = 1'b1;
        bus.ic_req_read = 1'b1;
        bus.ic_req_addr = 32'h1111;
        cyc();
        chk("lat_ic_read", 256'(bus.mmu_req_read), 256'd1);
        chk("lat_ic_addr", 256'(bus.mmu_req_addr), 256'h1111);
        mmu_ack(256'hBEEF);
        chk("lat_ic_done",  256'(bus.ic_done),  256'd1);
        chk("lat_ic_data",  bus.ic_read_data,   256'hBEEF);
        chk("lat_dc_done0", 256'(bus.dc_done),  256'd0);
        chk("lat_dc_data0", bus.dc_read_data,   256'd0);
        bus.ic_req_read = 1'b0;
        cyc(); mmu_idle();
        chk("lat_idle", 256'(bus.mmu_req_read), 256'd0);

        // Conflict: D (0x2000) before I (0x1000)
        bus.ic_req_read = 1'b1; bus.ic_req_addr = 32'h1000;
        bus.dc_req_read = 1'b1; bus.dc_req_addr = 32'h2000;
        cyc();
        chk("cfl_first_addr", 256'(bus.mmu_req_addr), 256'h2000);
        cyc();
        chk("cfl_first_hold", 256'(bus.mmu_req_addr), 256'h2000);
        mmu_ack(256'hD1);
        chk("cfl_dc_done", 256'(bus.dc_done), 256'd1);
        chk("cfl_dc_data", bus.dc_read_data,  256'hD1);
        chk("cfl_ic_done0", 256'(bus.ic_done), 256'd0);
        chk("cfl_ic_data0", bus.ic_read_data,  256'd0);
        bus.dc_req_read = 1'b0;
        cyc(); mmu_idle();
        chk("cfl_gap", 256'(bus.mmu_req_read), 256'd0);
        cyc();
        chk("cfl_second_addr", 256'(bus.mmu_req_addr), 256'h1000);
        mmu_ack(256'h11);
        chk("cfl_ic_done", 256'(bus.ic_done), 256'd1);
        chk("cfl_dc_done0", 256'(bus.dc_done), 256'd0);
        bus.ic_req_read = 1'b0;
        cyc(); mmu_idle();

        // mmu_done while IDLE is ignored
        mmu_ack(256'hFF);
        chk("idle_ic_done", 256'(bus.ic_done), 256'd0);
        chk("idle_dc_done", 256'(bus.dc_done), 256'd0);
        cyc(); mmu_idle();
        chk("idle_stay", 256'(bus.mmu_req_read), 256'd0);

        // Writeback chain: write 0x8000, then D read 0x4000 ahead of pending I
        bus.dc_req_write  = 1'b1;
        bus.dc_req_addr   = 32'h8000;
        bus.dc_write_data = a5_line;
        cyc();
        chk("wb_write", 256'(bus.mmu_req_write), 256'd1);
        chk("wb_addr",  256'(bus.mmu_req_addr),  256'h8000);
        chk("wb_wdata", bus.mmu_write_data,      a5_line);
        bus.ic_req_read = 1'b1; bus.ic_req_addr = 32'h1000;
        mmu_ack(256'd0);
        chk("wb_done", 256'(bus.dc_done), 256'd1);
        bus.dc_req_write  = 1'b0;
        bus.dc_write_data = '0;
        bus.dc_req_read   = 1'b1;
        bus.dc_req_addr   = 32'h4000;
        cyc(); mmu_idle();
        chk("wb_gap", 256'(bus.mmu_req_read | bus.mmu_req_write), 256'd0);
        cyc();
        chk("wb_refill_addr", 256'(bus.mmu_req_addr), 256'h4000);
        chk("wb_refill_read", 256'(bus.mmu_req_read), 256'd1);
        mmu_ack(256'h44);
        chk("wb_refill_done", 256'(bus.dc_done), 256'd1);
        bus.dc_req_read = 1'b0;
        cyc(); mmu_idle();
        cyc();
        chk("wb_ic_addr", 256'(bus.mmu_req_addr), 256'h1000);
        mmu_ack(256'h10);
        chk("wb_ic_done", 256'(bus.ic_done), 256'd1);
        bus.ic_req_read = 1'b0;
        cyc(); mmu_idle();

        // Dropped request: dc_req_read released 2 cycles in, done at cycle 5
        bus.dc_req_read = 1'b1;
        bus.dc_req_addr = 32'h6000;
        cyc();
        chk("drop_c1_read", 256'(bus.mmu_req_read), 256'd1);
        cyc();
        bus.dc_req_read = 1'b0;
        cyc();
        chk("drop_c3_read", 256'(bus.mmu_req_read), 256'd1);
        chk("drop_c3_addr", 256'(bus.mmu_req_addr), 256'h6000);
        cyc(); cyc();
        chk("drop_c5_read", 256'(bus.mmu_req_read), 256'd1);
        mmu_ack(256'h77);
        chk("drop_dc_done", 256'(bus.dc_done), 256'd1);
        chk("drop_dc_data", bus.dc_read_data,  256'h77);
        chk("drop_ic_done", 256'(bus.ic_done), 256'd0);
        cyc(); mmu_idle();
        chk("drop_dc_done_end", 256'(bus.dc_done), 256'd0);
        chk("drop_read_end",    256'(bus.mmu_req_read), 256'd0);

`ifdef ARB_ROUND_ROBIN_EN
        // Three conflicts after a D transaction: I, D, I
        rr_exp[0] = 32'h1000; rr_exp[1] = 32'h2000; rr_exp[2] = 32'h1000;
        bus.ic_req_read = 1'b1; bus.ic_req_addr = 32'h1000;
        bus.dc_req_read = 1'b1; bus.dc_req_addr = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("rr_grant%0d", k), 256'(bus.mmu_req_addr), 256'(rr_exp[k]));
            mmu_ack(256'(k));
            if (k == 2) begin
                bus.ic_req_read = 1'b0;
                bus.dc_req_read = 1'b0;
            end
            cyc(); mmu_idle();
        end
`else
        rr_exp[0] = 32'h0; rr_exp[1] = 32'h0; rr_exp[2] = 32'h0;
`endif

        // Watchdog with TIMEOUT_CYCLES=8
        bus.dc_req_read = 1'b1;
        bus.dc_req_addr = 32'h9000;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("wd_cycle%0d", k), 256'(bus.arb_timeout), (k == 8) ? 256'd1 : 256'd0);
        end
        chk("wd_not_aborted", 256'(bus.mmu_req_read), 256'd1);
        mmu_ack(256'h99);
        chk("wd_dc_done", 256'(bus.dc_done), 256'd1);
        bus.dc_req_read = 1'b0;
        cyc(); mmu_idle();
        chk("wd_sticky1", 256'(bus.arb_timeout), 256'd1);
        cyc();
        chk("wd_sticky2", 256'(bus.arb_timeout), 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
